vga_timing_gen: RTL and testbench

Generates the VGA raster timing consumed by the pixel generator: free-running hCount/vCount, active-low hSync/vSync, and the bright window, all from the 100 MHz system clock through a 25 MHz pixel clock-enable. Its outputs drive the hCount/vCount/bright inputs of the RGB generator and the board's sync pins. It also emits per-pixel and per-frame strobes and a frame counter for game-state and animation timing.

---
 rtl/vga_timing_gen.sv | 88 ++++++++
 tb/tb_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, active-low syncs,
// visible-window flag, plus per-pixel and per-frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV        = 4,
    parameter int H_TOTAL        = 800,
    parameter int H_SYNC         = 96,
    parameter int H_BRIGHT_START = 144,
    parameter int H_BRIGHT_END   = 784,
    parameter int V_TOTAL        = 525,
    parameter int V_SYNC         = 2,
    parameter int V_BRIGHT_START = 35,
    parameter int V_BRIGHT_END   = 515
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_en,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_BR_LO  = 10'(H_BRIGHT_START);
    localparam logic [9:0] H_BR_HI  = 10'(H_BRIGHT_END);
    localparam logic [9:0] V_BR_LO  = 10'(V_BRIGHT_START);
    localparam logic [9:0] V_BR_HI  = 10'(V_BRIGHT_END);

    logic [3:0] div;
    logic       advance;
    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] h_next;
    logic [9:0] v_next;

    // Next-state counters; the sync/bright decode uses these so they switch
    // on the same edge as the counters themselves.
    always_comb begin
        advance = (div == DIV_LAST);
        h_wrap  = (hCount == H_LAST);
        v_wrap  = (vCount == V_LAST);
        h_next  = hCount;
        v_next  = vCount;
        if (advance) begin
            if (h_wrap) begin
                h_next = 10'd0;
                v_next = v_wrap ? 10'd0 : vCount + 10'd1;
            end else begin
                h_next = hCount + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= 4'd0;
            hCount      <= 10'd0;
            vCount      <= 10'd0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            pix_en      <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            div         <= advance ? 4'd0 : div + 4'd1;
            hCount      <= h_next;
            vCount      <= v_next;
            hSync       <= !(h_next < H_SYNC_W);
            vSync       <= !(v_next < V_SYNC_W);
            bright      <= (h_next >= H_BR_LO) && (h_next < H_BR_HI) &&
                           (v_next >= V_BR_LO) && (v_next < V_BR_HI);
            pix_en      <= advance;
            frame_start <= advance && h_wrap && v_wrap;
            if (advance && h_wrap && v_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 10x5 raster (4 clks/pixel,
// 200 clks/frame) so full frames and the 256-frame wrap stay short.
module tb_vga_timing_gen;

    localparam int CLK_DIV  = 4;
    localparam int H_TOTAL  = 10;
    localparam int V_TOTAL  = 5;
    localparam int LINE_CLK = H_TOTAL * CLK_DIV;
    localparam int FRAME_CLK = LINE_CLK * V_TOTAL;

    logic       clk;
    logic       rst;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       pix_en;
    logic       frame_start;
    logic [7:0] frame_count;

    int checks;
    int errors;
    int cyc;
    int h_low;
    int v_low;
    int bright_clks;
    int bright_vblank;
    int pix_clks;
    int fs_clks;
    int dbl_pix;
    logic prev_pix;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV),
        .H_TOTAL(H_TOTAL),
        .H_SYNC(2),
        .H_BRIGHT_START(3),
        .H_BRIGHT_END(8),
        .V_TOTAL(V_TOTAL),
        .V_SYNC(1),
        .V_BRIGHT_START(1),
        .V_BRIGHT_END(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hCount(hCount),
        .vCount(vCount),
        .hSync(hSync),
        .vSync(vSync),
        .bright(bright),
        .pix_en(pix_en),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive rst (caller is already between clock edges) and restart the clk tally.
    task automatic applyStimulus(input logic rst_val);
        rst           = rst_val;
        cyc           = 0;
        h_low         = 0;
        v_low         = 0;
        bright_clks   = 0;
        bright_vblank = 0;
        pix_clks      = 0;
        fs_clks       = 0;
        dbl_pix       = 0;
        prev_pix      = 1'b0;
    endtask

    // One rising edge, then sample 1 ns later and accumulate the event tallies.
    task automatic advanceClock();
        @(posedge clk);
        #1;
        cyc++;
        if (!hSync) h_low++;
        if (!vSync) v_low++;
        if (bright) bright_clks++;
        if (bright && (vCount < 10'd1 || vCount >= 10'd4)) bright_vblank++;
        if (pix_en) pix_clks++;
        if (frame_start) fs_clks++;
        if (pix_en && prev_pix) dbl_pix++;
        prev_pix = pix_en;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) advanceClock();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_hCount"}, 32'(hCount), 32'd0);
        checkOutput({tag, "_vCount"}, 32'(vCount), 32'd0);
        checkOutput({tag, "_hSync"}, 32'(hSync), 32'd0);
        checkOutput({tag, "_vSync"}, 32'(vSync), 32'd0);
        checkOutput({tag, "_bright"}, 32'(bright), 32'd0);
        checkOutput({tag, "_pix_en"}, 32'(pix_en), 32'd0);
        checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        checkOutput({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        applyStimulus(1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");

        // Release between edges; first advance lands on the 4th edge.
        #2;
        applyStimulus(1'b0);
        for (int i = 1; i <= 3; i++) begin
            advanceClock();
            checkOutput($sformatf("hold%0d_hCount", i), 32'(hCount), 32'd0);
            checkOutput($sformatf("hold%0d_pix_en", i), 32'(pix_en), 32'd0);
        end
        advanceClock();
        checkOutput("clk4_hCount", 32'(hCount), 32'd1);
        checkOutput("clk4_pix_en", 32'(pix_en), 32'd1);
        advanceClock();
        checkOutput("clk5_pix_en", 32'(pix_en), 32'd0);
        runTo(8);
        checkOutput("clk8_hCount", 32'(hCount), 32'd2);
        checkOutput("clk8_pix_en", 32'(pix_en), 32'd1);

        // End of first line and horizontal wrap.
        runTo(LINE_CLK - 1);
        checkOutput("eol_hCount", 32'(hCount), 32'd9);
        checkOutput("eol_vCount", 32'(vCount), 32'd0);
        checkOutput("eol_hSync", 32'(hSync), 32'd1);
        advanceClock();
        checkOutput("hwrap_hCount", 32'(hCount), 32'd0);
        checkOutput("hwrap_vCount", 32'(vCount), 32'd1);
        checkOutput("hwrap_hSync", 32'(hSync), 32'd0);
        checkOutput("hsync_low_clks", 32'(h_low), 32'd8);

        // Bright edges on the first visible line.
        runTo(LINE_CLK + 11);
        checkOutput("pre_bright", 32'(bright), 32'd0);
        advanceClock();
        checkOutput("bright_rise", 32'(bright), 32'd1);
        checkOutput("bright_rise_hCount", 32'(hCount), 32'd3);
        runTo(LINE_CLK + 31);
        checkOutput("bright_last", 32'(bright), 32'd1);
        advanceClock();
        checkOutput("bright_fall", 32'(bright), 32'd0);
        checkOutput("bright_fall_hCount", 32'(hCount), 32'd8);

        // Full frame and the (0,0) wrap.
        runTo(FRAME_CLK - 1);
        checkOutput("eof_hCount", 32'(hCount), 32'd9);
        checkOutput("eof_vCount", 32'(vCount), 32'd4);
        checkOutput("eof_frame_start", 32'(frame_start), 32'd0);
        checkOutput("eof_frame_count", 32'(frame_count), 32'd0);
        advanceClock();
        checkOutput("fwrap_hCount", 32'(hCount), 32'd0);
        checkOutput("fwrap_vCount", 32'(vCount), 32'd0);
        checkOutput("fwrap_frame_start", 32'(frame_start), 32'd1);
        checkOutput("fwrap_pix_en", 32'(pix_en), 32'd1);
        checkOutput("fwrap_frame_count", 32'(frame_count), 32'd1);
        checkOutput("frame_bright_clks", 32'(bright_clks), 32'd60);
        checkOutput("frame_bright_vblank", 32'(bright_vblank), 32'd0);
        checkOutput("frame_vsync_low", 32'(v_low), 32'd40);
        checkOutput("frame_pix_pulses", 32'(pix_clks), 32'd50);
        checkOutput("frame_fs_pulses", 32'(fs_clks), 32'd1);
        checkOutput("frame_double_pix", 32'(dbl_pix), 32'd0);
        advanceClock();
        checkOutput("post_fs_frame_start", 32'(frame_start), 32'd0);
        checkOutput("post_fs_frame_count", 32'(frame_count), 32'd1);

        // Asynchronous reset while sitting at (4,2) inside the visible window.
        runTo(FRAME_CLK + 2 * LINE_CLK + 4 * CLK_DIV + 1);
        checkOutput("mid_hCount", 32'(hCount), 32'd4);
        checkOutput("mid_vCount", 32'(vCount), 32'd2);
        checkOutput("mid_bright", 32'(bright), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkResetState("async");
        repeat (3) @(posedge clk);
        #3;
        applyStimulus(1'b0);
        runTo(3);
        checkOutput("rerun_clk3_hCount", 32'(hCount), 32'd0);
        checkOutput("rerun_clk3_pix_en", 32'(pix_en), 32'd0);
        advanceClock();
        checkOutput("rerun_clk4_hCount", 32'(hCount), 32'd1);
        checkOutput("rerun_clk4_pix_en", 32'(pix_en), 32'd1);
        runTo(FRAME_CLK - 1);
        checkOutput("rerun_no_fs", 32'(fs_clks), 32'd0);
        checkOutput("rerun_frame_count", 32'(frame_count), 32'd0);

        // 256 frames: frame_count wraps to 0 on the 256th frame_start.
        runTo(FRAME_CLK * 255);
        checkOutput("fc_255", 32'(frame_count), 32'd255);
        runTo(FRAME_CLK * 256 - 1);
        checkOutput("fc_pre_wrap", 32'(frame_count), 32'd255);
        advanceClock();
        checkOutput("fc_wrap", 32'(frame_count), 32'd0);
        checkOutput("fc_wrap_frame_start", 32'(frame_start), 32'd1);
        checkOutput("fc_total_fs", 32'(fs_clks), 32'd256);
        checkOutput("fc_double_pix", 32'(dbl_pix), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
